// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   // Index width needed to address n requesters; never below one bit.
   function automatic int calc_idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping once around the requester ring.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N   = 8,
   parameter int IDW = calc_idw(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           any,
   output logic [IDW-1:0] idx
);

   // Lower copy keeps only requesters at or above ptr; upper copy is the
   // unmasked wrap-around, so one LSB-first scan covers ptr..N-1, 0..ptr-1.
   logic [2*N-1:0] req_dbl;

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_mask
         assign req_dbl[g]     = req[g] & (ptr <= IDW'(g));
         assign req_dbl[N + g] = req[g];
      end
   endgenerate

   always_comb begin
      // NOTE: combinational logic uses blocking assignments with every output
      // defaulted first, so the loop reads its own partial result and no latch forms.
      any = 1'b0;
      idx = '0;
      for (int j = 0; j < 2 * N; j++) begin
         if (req_dbl[j] && !any) begin
            any = 1'b1;
            idx = IDW'(j % N);
         end
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with held grants and a rotating priority pointer.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX+1 consecutive grant cycles.
module rr_grant_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 8,
   parameter int IDW      = calc_idw(N),
   parameter int HOLD_MAX = 15
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic [IDW-1:0] ptr,
   output logic           preempt
);

   arb_state_e     state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0] id_q, id_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic           preempt_q, preempt_d;

   logic           pick_any;
   logic [IDW-1:0] pick_idx;
   logic [IDW-1:0] ptr_next;
   logic           owner_req;
   logic           timeout_hit;
   logic           drop_grant;

   rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign owner_req  = req[id_q];
   assign drop_grant = (state_q == OWN) && (!owner_req || timeout_hit);
   // Explicit wrap keeps ptr inside 0..N-1 for non-power-of-two N.
   assign ptr_next   = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
   localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

   logic [HW-1:0] hold_q, hold_d;

   assign timeout_hit = (hold_q == HW'(HOLD_MAX));

   always_comb begin
      hold_d = hold_q;
      if (state_q == IDLE) begin
         hold_d = '0;
      end else if (!drop_grant) begin
         hold_d = hold_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   logic unused_hold_max;

   assign unused_hold_max = (HOLD_MAX != 0);
   assign timeout_hit     = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      id_d      = id_q;
      ptr_d     = ptr_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = OWN;
               gnt_d   = N'(1) << pick_idx;
               id_d    = pick_idx;
            end
         end
         OWN: begin
            // Other requesters are ignored until the owner lets go.
            if (drop_grant) begin
               state_d   = IDLE;
               gnt_d     = '0;
               id_d      = '0;
               ptr_d     = ptr_next;
               preempt_d = owner_req;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         id_q      <= '0;
         ptr_q     <= '0;
         preempt_q <= 1'b0;
      end else begin
         // NOTE: registered state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         id_q      <= id_d;
         ptr_q     <= ptr_d;
         preempt_q <= preempt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = |gnt_q;
   assign gnt_id    = id_q;
   assign ptr       = ptr_q;
   assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench: three arbiter instances (N=8, N=8 with short hold limit,
// N=5) compared every cycle against an owner/pointer reference model.
module tb_rr_grant_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req8;
   logic [4:0] req5;

   logic [7:0] gnt_a, gnt_t;
   logic [4:0] gnt_c;
   logic       valid_a, valid_t, valid_c;
   logic [2:0] id_a, id_t, id_c;
   logic [2:0] ptr_a, ptr_t, ptr_c;
   logic       pre_a, pre_t, pre_c;

   always #5 clk = ~clk;

   rr_grant_arbiter #(.N(8), .IDW(3), .HOLD_MAX(15)) u_dut_a (
      .clk(clk), .rst(rst), .req(req8), .gnt(gnt_a), .gnt_valid(valid_a),
      .gnt_id(id_a), .ptr(ptr_a), .preempt(pre_a));

   rr_grant_arbiter #(.N(8), .IDW(3), .HOLD_MAX(3)) u_dut_t (
      .clk(clk), .rst(rst), .req(req8), .gnt(gnt_t), .gnt_valid(valid_t),
      .gnt_id(id_t), .ptr(ptr_t), .preempt(pre_t));

   rr_grant_arbiter #(.N(5), .IDW(3), .HOLD_MAX(15)) u_dut_c (
      .clk(clk), .rst(rst), .req(req5), .gnt(gnt_c), .gnt_valid(valid_c),
      .gnt_id(id_c), .ptr(ptr_c), .preempt(pre_c));

   // owner = -1 when nobody holds the resource; held = cycles the grant has been visible.
   typedef struct {
      int owner;
      int ptr;
      int held;
      bit pre;
   } mdl_t;

   mdl_t m_a, m_t, m_c;
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.owner = -1;
      m.ptr   = 0;
      m.held  = 0;
      m.pre   = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, logic [31:0] r, int n, int hold_max);
      mdl_t s = m;
      bit found = 1'b0;
      bit expired;
      s.pre   = 1'b0;
      expired = TIMEOUT_ON && (m.held == hold_max + 1);
      if (m.owner < 0) begin
         for (int o = 0; o < n; o++) begin
            int k;
            k = (m.ptr + o) % n;
            if (!found && r[k]) begin
               found   = 1'b1;
               s.owner = k;
               s.held  = 1;
            end
         end
      end else if (!r[m.owner] || expired) begin
         s.pre   = r[m.owner];
         s.ptr   = (m.owner + 1) % n;
         s.owner = -1;
         s.held  = 0;
      end else begin
         s.held = m.held + 1;
      end
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_inst(input string name, input logic [31:0] g, input logic v,
                             input logic [31:0] id, input logic [31:0] p, input logic pr,
                             input mdl_t m);
      logic [31:0] exp_gnt;
      exp_gnt = (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0;
      check({name, " gnt"},       g,  exp_gnt);
      check({name, " gnt_valid"}, {31'd0, v}, {31'd0, m.owner >= 0});
      check({name, " gnt_id"},    id, (m.owner >= 0) ? 32'(m.owner) : 32'd0);
      check({name, " ptr"},       p,  32'(m.ptr));
      check({name, " preempt"},   {31'd0, pr}, {31'd0, m.pre});
   endtask

   task automatic check_all();
      check_inst("a", 32'(gnt_a), valid_a, 32'(id_a), 32'(ptr_a), pre_a, m_a);
      check_inst("t", 32'(gnt_t), valid_t, 32'(id_t), 32'(ptr_t), pre_t, m_t);
      check_inst("c", 32'(gnt_c), valid_c, 32'(id_c), 32'(ptr_c), pre_c, m_c);
   endtask

   // Drive one cycle of requests from a falling edge, advance the model, check at the next falling edge.
   task automatic tick(input logic [7:0] r8, input logic [4:0] r5);
      req8 = r8;
      req5 = r5;
      m_a  = mdl_step(m_a, 32'(r8), 8, 15);
      m_t  = mdl_step(m_t, 32'(r8), 8, 3);
      m_c  = mdl_step(m_c, 32'(r5), 5, 15);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic [7:0] r8;
      logic [4:0] r5;

      rst  = 1'b1;
      req8 = '0;
      req5 = '0;
      m_a  = mdl_reset();
      m_t  = mdl_reset();
      m_c  = mdl_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b0;

      // Asynchronous reset while requester 2 owns the resource.
      tick(8'h04, 5'h00);
      check("own before reset", 32'(gnt_a), 32'h04);
      tick(8'h04, 5'h00);
      #2;
      rst = 1'b1;
      #1;
      check("async rst gnt", 32'(gnt_a), 32'h00);
      check("async rst ptr", 32'(ptr_a), 32'h00);
      m_a = mdl_reset();
      m_t = mdl_reset();
      m_c = mdl_reset();
      @(negedge clk);
      rst = 1'b0;
      check_all();
      for (int i = 0; i < 10; i++) begin
         tick(8'h00, 5'h00);
         check("idle valid", {31'd0, valid_a}, 32'd0);
      end

      // Fairness: everyone requests, each owner drops for a cycle after two grant cycles.
      for (int g = 0; g < 9; g++) begin
         logic [7:0] drop;
         drop = 8'hFF & ~(8'h01 << (g % 8));
         tick(8'hFF, 5'h00);
         check("fair order", 32'(id_a), 32'(g % 8));
         tick(8'hFF, 5'h00);
         tick(drop, 5'h00);
         check("fair bubble", {31'd0, valid_a}, 32'd0);
      end

      // Single requester: grant at t+1, drop at t+5, idle at t+6 with ptr past it.
      tick(8'h10, 5'h00);
      check("single gnt", 32'(gnt_a), 32'h10);
      check("single id", 32'(id_a), 32'd4);
      repeat (4) tick(8'h10, 5'h00);
      tick(8'h00, 5'h00);
      check("single drop gnt", 32'(gnt_a), 32'h00);
      check("single drop ptr", 32'(ptr_a), 32'd5);

      // Wrap-around search from ptr=6.
      tick(8'h20, 5'h00);
      tick(8'h00, 5'h00);
      check("wrap ptr6", 32'(ptr_a), 32'd6);
      tick(8'h05, 5'h00);
      check("wrap id0", 32'(id_a), 32'd0);
      tick(8'h04, 5'h00);
      check("wrap ptr1", 32'(ptr_a), 32'd1);
      check("wrap bubble", {31'd0, valid_a}, 32'd0);
      tick(8'h04, 5'h00);
      check("wrap id2", 32'(id_a), 32'd2);
      tick(8'h00, 5'h00);

      // Hold limit on the HOLD_MAX=3 instance alongside the N=5 pointer wrap.
      for (int c = 1; c <= 6; c++) begin
         tick(8'h03, (c == 1) ? 5'h10 : 5'h00);
         if (c == 1) begin
            check("n5 gnt", 32'(gnt_c), 32'h10);
            check("n5 id", 32'(id_c), 32'd4);
         end
         if (c == 2) begin
            check("n5 ptr wrap", 32'(ptr_c), 32'd0);
            check("n5 bubble", {31'd0, valid_c}, 32'd0);
         end
`ifdef ARB_TIMEOUT_EN
         if (c <= 4) begin
            check("timeout hold", 32'(gnt_t), 32'h01);
         end else if (c == 5) begin
            check("timeout preempt", {31'd0, pre_t}, 32'd1);
            check("timeout gnt drop", 32'(gnt_t), 32'h00);
         end else begin
            check("timeout next", 32'(gnt_t), 32'h02);
         end
`else
         check("no timeout hold", 32'(gnt_t), 32'h01);
         check("no timeout preempt", {31'd0, pre_t}, 32'd0);
`endif
      end
      tick(8'h00, 5'h00);

      // Random phase: each request bit toggles with probability 1/4 per cycle.
      r8 = '0;
      r5 = '0;
      for (int i = 0; i < 600; i++) begin
         r8 = r8 ^ 8'($urandom & $urandom);
         r5 = r5 ^ 5'($urandom & $urandom);
         tick(r8, r5);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
